// File: rtl/axil_to_pcie_mwr_if.sv
// AXI4-Lite slave bus plus 7-series TX AXIS stream for the MWr bridge.
// slave = bridge side, master = fabric/core side.
interface axil_to_pcie_mwr_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [63:0] m_axis_tx_tdata;
    logic [7:0]  m_axis_tx_tkeep;
    logic        m_axis_tx_tlast;
    logic        m_axis_tx_tvalid;
    logic [3:0]  m_axis_tx_tuser;
    logic        m_axis_tx_tready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tx_tready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
               m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tvalid, m_axis_tx_tuser
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, m_axis_tx_tready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
               m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast, m_axis_tx_tvalid, m_axis_tx_tuser
    );
endinterface

// File: rtl/axil_to_pcie_mwr.sv
// AXI4-Lite write -> 1-DW MWr32 TLP on the 64-bit 7-series TX AXIS.
// One write outstanding; reads are refused with SLVERR.
module axil_to_pcie_mwr #(
    parameter int WIN_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           cfg_completer_id,
    input  logic                  cfg_bus_master_en,
    input  logic [31:0]           win_base,
    axil_to_pcie_mwr_if.slave     bus,
    output logic [15:0]           tlp_count,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, HDR, DAT, RESP} state_t;

    state_t                  state;
    logic                    aw_lat, w_lat;
    logic                    awready, wready, bvalid;
    logic [1:0]              bresp;
    logic [WIN_BITS-1:2]     awaddr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic                    tvalid, tlast;
    logic [63:0]             tdata;
    logic                    arready, rvalid;
    logic [1:0]              rresp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            aw_lat    <= 1'b0;
            w_lat     <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            tvalid    <= 1'b0;
            tlast     <= 1'b0;
            tdata     <= '0;
            tlp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_axi_awvalid && awready) begin
                        aw_lat   <= 1'b1;
                        awready  <= 1'b0;
                        awaddr_q <= bus.s_axi_awaddr[WIN_BITS-1:2];
                    end else if (!aw_lat) begin
                        awready  <= 1'b1;
                    end
                    if (bus.s_axi_wvalid && wready) begin
                        w_lat   <= 1'b1;
                        wready  <= 1'b0;
                        wdata_q <= bus.s_axi_wdata;
                        wstrb_q <= bus.s_axi_wstrb;
                    end else if (!w_lat) begin
                        wready  <= 1'b1;
                    end
                    // Decision is taken the cycle after both halves are held.
                    if (aw_lat && w_lat) begin
                        if (!cfg_bus_master_en) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bresp  <= 2'b10;
                        end else if (wstrb_q == 4'h0) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bresp  <= 2'b00;
                        end else begin
                            state  <= HDR;
                            tvalid <= 1'b1;
                            tlast  <= 1'b0;
                            tdata  <= {cfg_completer_id, 8'h00, 4'h0, wstrb_q, 32'h4000_0001};
                        end
                    end
                end
                HDR: begin
                    if (bus.m_axis_tx_tready) begin
                        state <= DAT;
                        tlast <= 1'b1;
                        tdata <= {wdata_q, win_base[31:WIN_BITS], awaddr_q, 2'b00};
                    end
                end
                DAT: begin
                    if (bus.m_axis_tx_tready) begin
                        state     <= RESP;
                        tvalid    <= 1'b0;
                        tlast     <= 1'b0;
                        tlp_count <= tlp_count + 16'd1;
                        bvalid    <= 1'b1;
                        bresp     <= 2'b00;
                    end
                end
                RESP: begin
                    if (bus.s_axi_bready) begin
                        state   <= IDLE;
                        bvalid  <= 1'b0;
                        aw_lat  <= 1'b0;
                        w_lat   <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read side never touches the write FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= 2'b00;
        end else if (bus.s_axi_arvalid && arready) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= 2'b10;
        end else if (rvalid && bus.s_axi_rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
        end else if (!rvalid) begin
            arready <= 1'b1;
        end
    end

    assign busy                 = (state != IDLE);
    assign bus.s_axi_awready    = awready;
    assign bus.s_axi_wready     = wready;
    assign bus.s_axi_bvalid     = bvalid;
    assign bus.s_axi_bresp      = bresp;
    assign bus.s_axi_arready    = arready;
    assign bus.s_axi_rvalid     = rvalid;
    assign bus.s_axi_rresp      = rresp;
    assign bus.s_axi_rdata      = 32'h0;
    assign bus.m_axis_tx_tvalid = tvalid;
    assign bus.m_axis_tx_tlast  = tlast;
    assign bus.m_axis_tx_tdata  = tdata;
    assign bus.m_axis_tx_tkeep  = 8'hFF;
    assign bus.m_axis_tx_tuser  = 4'h0;

    logic unused_ok;
    assign unused_ok = ^{bus.s_axi_araddr, bus.s_axi_awaddr[31:WIN_BITS],
                         bus.s_axi_awaddr[1:0], win_base[WIN_BITS-1:0]};
endmodule

// File: tb/tb_axil_to_pcie_mwr.sv
// Randomized bench for axil_to_pcie_mwr: queue-based TLP/response model,
// one negedge compare process, directed scenarios with literal expectations.
module tb_axil_to_pcie_mwr;
    localparam int WIN_BITS = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_id = 16'h0100;
    logic        bme = 1'b1;
    logic [31:0] win = 32'h8000_0000;
    logic [15:0] tlp_count;
    logic        busy;

    axil_to_pcie_mwr_if ifc();

    axil_to_pcie_mwr #(.WIN_BITS(WIN_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_completer_id(cfg_id),
        .cfg_bus_master_en(bme), .win_base(win), .bus(ifc),
        .tlp_count(tlp_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    // Reference: what a 1-DW MWr32 for this write must look like.
    function automatic void model_tlp(input logic [31:0] a, d, input logic [3:0] s,
                                      input logic [15:0] id, input logic [31:0] wb,
                                      output logic [63:0] b0, b1);
        logic [31:0] mask, addr;
        mask = (32'h1 << WIN_BITS) - 32'h1;
        addr = (wb & ~mask) | (a & mask & 32'hFFFF_FFFC);
        b0 = {id, 8'h00, 4'h0, s, 32'h4000_0001};
        b1 = {d, addr};
    endfunction

    logic [64:0] exp_beats[$];
    logic [1:0]  exp_b[$];
    int          model_cnt = 0, n_beats = 0, pend_rd = 0;
    logic [63:0] last_b0 = '0, last_b1 = '0;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    logic        prev_last;

    // tready: pattern (consumed only while tvalid), random, or held high.
    bit tr_pat[$];
    bit tr_rand = 0;
    initial begin
        ifc.m_axis_tx_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tr_pat.size() > 0 && ifc.m_axis_tx_tvalid) ifc.m_axis_tx_tready = tr_pat.pop_front();
            else if (tr_pat.size() == 0) ifc.m_axis_tx_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst_n) prev_stall = 0;
        else begin
            chk("tlp_count", 64'(tlp_count), 64'(model_cnt));
            if (prev_stall) begin
                chk("tx_hold_valid", 64'(ifc.m_axis_tx_tvalid), 64'd1);
                chk("tx_hold_data", ifc.m_axis_tx_tdata, prev_data);
                chk("tx_hold_last", 64'(ifc.m_axis_tx_tlast), 64'(prev_last));
            end
            if (ifc.m_axis_tx_tvalid) begin
                chk("tuser", 64'(ifc.m_axis_tx_tuser), 64'd0);
                chk("tkeep", 64'(ifc.m_axis_tx_tkeep), 64'hFF);
            end
            if (ifc.m_axis_tx_tvalid && ifc.m_axis_tx_tready) begin
                n_beats++;
                if (exp_beats.size() == 0) chk("unexpected_beat", ifc.m_axis_tx_tdata, 64'hx);
                else begin
                    e = exp_beats.pop_front();
                    chk("tx_data", ifc.m_axis_tx_tdata, e[63:0]);
                    chk("tx_last", 64'(ifc.m_axis_tx_tlast), 64'(e[64]));
                    if (e[64]) begin
                        last_b1 = ifc.m_axis_tx_tdata;
                        model_cnt = (model_cnt + 1) % 65536;
                    end else last_b0 = ifc.m_axis_tx_tdata;
                end
            end
            prev_stall = ifc.m_axis_tx_tvalid && !ifc.m_axis_tx_tready;
            prev_data  = ifc.m_axis_tx_tdata;
            prev_last  = ifc.m_axis_tx_tlast;
            if (ifc.s_axi_bvalid && ifc.s_axi_bready) begin
                if (exp_b.size() == 0) chk("unexpected_b", 64'(ifc.s_axi_bresp), 64'hx);
                else chk("bresp", 64'(ifc.s_axi_bresp), 64'(exp_b.pop_front()));
            end
            if (ifc.s_axi_rvalid) chk("arready_while_rvalid", 64'(ifc.s_axi_arready), 64'd0);
            if (ifc.s_axi_rvalid && ifc.s_axi_rready) begin
                chk("read_pending", 64'(pend_rd > 0), 64'd1);
                if (pend_rd > 0) pend_rd--;
                chk("rresp", 64'(ifc.s_axi_rresp), 64'd2);
                chk("rdata", 64'(ifc.s_axi_rdata), 64'd0);
            end
        end
    end

    // Presents AW/W with independent delays until both handshake; records model expectations.
    task automatic issue(input logic [31:0] a, d, input logic [3:0] s,
                         input int aw_dly, w_dly, output int cap);
        logic [63:0] b0, b1;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int early = 0;
        if (bme && s != 4'h0) begin
            model_tlp(a, d, s, cfg_id, win, b0, b1);
            exp_beats.push_back({1'b0, b0});
            exp_beats.push_back({1'b1, b1});
        end
        exp_b.push_back(bme ? 2'b00 : 2'b10);
        for (int t = 0; t < 100; t++) begin
            ifc.s_axi_awvalid = !aw_done && t >= aw_dly;
            ifc.s_axi_awaddr  = ifc.s_axi_awvalid ? a : $urandom;
            ifc.s_axi_wvalid  = !w_done && t >= w_dly;
            ifc.s_axi_wdata   = ifc.s_axi_wvalid ? d : $urandom;
            ifc.s_axi_wstrb   = ifc.s_axi_wvalid ? s : 4'($urandom);
            @(negedge clk);
            hs_aw = ifc.s_axi_awvalid && ifc.s_axi_awready;
            hs_w  = ifc.s_axi_wvalid && ifc.s_axi_wready;
            if (ifc.m_axis_tx_tvalid) early++;
            @(posedge clk); #1;
            aw_done |= hs_aw;
            w_done  |= hs_w;
            if (aw_done && w_done) break;
        end
        ifc.s_axi_awvalid = 1'b0;
        ifc.s_axi_wvalid  = 1'b0;
        ifc.s_axi_awaddr  = $urandom;
        ifc.s_axi_wdata   = $urandom;
        ifc.s_axi_wstrb   = 4'($urandom);
        chk("aw_w_handshake", 64'({aw_done, w_done}), 64'd3);
        chk("no_early_tlp", 64'(early), 64'd0);
        cap = cyc;
    endtask

    task automatic complete(input int bhold, input int cap, output int lat);
        bit seen = 0;
        lat = -1;
        ifc.s_axi_bready = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ifc.s_axi_bvalid) begin seen = 1; lat = cyc - cap; break; end
            @(posedge clk); #1;
        end
        chk("bvalid_timeout", 64'(seen), 64'd1);
        if (!seen) return;
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 64'(ifc.s_axi_bvalid), 64'd1);
            chk("awready_hold", 64'(ifc.s_axi_awready), 64'd0);
            chk("busy_hold", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        ifc.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        ifc.s_axi_bready = 1'b0;
        chk("bvalid_clear", 64'(ifc.s_axi_bvalid), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("ready_back", 64'({ifc.s_axi_awready, ifc.s_axi_wready}), 64'd3);
    endtask

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                            input int aw_dly, w_dly, bhold, output int lat);
        int cap;
        issue(a, d, s, aw_dly, w_dly, cap);
        complete(bhold, cap, lat);
    endtask

    task automatic do_read(input int rdly);
        bit hs = 0;
        ifc.s_axi_arvalid = 1'b1;
        ifc.s_axi_araddr  = $urandom;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            hs = ifc.s_axi_arvalid && ifc.s_axi_arready;
            @(posedge clk); #1;
            if (hs) break;
        end
        ifc.s_axi_arvalid = 1'b0;
        chk("ar_handshake", 64'(hs), 64'd1);
        if (!hs) return;
        pend_rd++;
        for (int i = 0; i < rdly; i++) begin
            chk("rvalid_hold", 64'(ifc.s_axi_rvalid), 64'd1);
            @(posedge clk); #1;
        end
        chk("rvalid_up", 64'(ifc.s_axi_rvalid), 64'd1);
        ifc.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        ifc.s_axi_rready = 1'b0;
        chk("rvalid_clear", 64'(ifc.s_axi_rvalid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b_before;
        logic [63:0] m0, m1;
        ifc.s_axi_awvalid = 0; ifc.s_axi_wvalid = 0; ifc.s_axi_bready = 0;
        ifc.s_axi_arvalid = 0; ifc.s_axi_rready = 0;
        ifc.s_axi_awaddr = 0; ifc.s_axi_wdata = 0; ifc.s_axi_wstrb = 0; ifc.s_axi_araddr = 0;

        // Pin the model against hand-derived TLPs.
        model_tlp(32'h0000_1234, 32'hCAFE_F00D, 4'hF, 16'h0100, 32'h8000_0000, m0, m1);
        chk("model_b0", m0, 64'h0100000F_40000001);
        chk("model_b1", m1, 64'hCAFEF00D_80001234);
        model_tlp(32'hFFF4_567B, 32'h0, 4'h3, 16'hABCD, 32'h1234_5678, m0, m1);
        chk("model_b0_strb", m0, 64'hABCD0003_40000001);
        chk("model_b1_win", m1, 64'h00000000_12345678);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({ifc.s_axi_awready, ifc.s_axi_wready, ifc.s_axi_arready}), 64'd0);
        chk("rst_valid", 64'({ifc.s_axi_bvalid, ifc.s_axi_rvalid, ifc.m_axis_tx_tvalid, ifc.m_axis_tx_tlast}), 64'd0);
        chk("rst_data", ifc.m_axis_tx_tdata, 64'd0);
        chk("rst_resp", 64'({ifc.s_axi_bresp, ifc.s_axi_rresp, ifc.s_axi_rdata}), 64'd0);
        chk("rst_cnt_busy", 64'({tlp_count, busy}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'({ifc.s_axi_awready, ifc.s_axi_wready, ifc.s_axi_arready}), 64'd7);

        // 1: same-cycle AW/W, tready high.
        do_write(32'h0000_1234, 32'hCAFE_F00D, 4'hF, 0, 0, 0, lat);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_beat0", last_b0, 64'h0100000F_40000001);
        chk("t1_beat1", last_b1, 64'hCAFEF00D_80001234);
        chk("t1_count", 64'(tlp_count), 64'd1);

        // 2: W leads AW by 5 cycles.
        b_before = n_beats;
        do_write(32'h0000_0040, 32'h1357_9BDF, 4'h3, 5, 0, 1, lat);
        chk("t2_beats", 64'(n_beats - b_before), 64'd2);
        chk("t2_firstbe", 64'(last_b0[39:32]), 64'h03);

        // 3: tready stalls inside the TLP.
        tr_pat = '{0, 1, 0, 0, 1};
        b_before = n_beats;
        do_write(32'h000A_BCD8, 32'hDEAD_BEEF, 4'hC, 0, 2, 0, lat);
        chk("t3_beats", 64'(n_beats - b_before), 64'd2);
        chk("t3_count", 64'(tlp_count), 64'd3);
        tr_pat.delete();

        // 4: bus master disabled, then empty strobe.
        b_before = n_beats;
        bme = 1'b0;
        do_write(32'h0000_0100, 32'h1111_1111, 4'hF, 0, 0, 0, lat);
        bme = 1'b1;
        do_write(32'h0000_0104, 32'h2222_2222, 4'h0, 1, 0, 0, lat);
        chk("t4_no_beats", 64'(n_beats - b_before), 64'd0);
        chk("t4_count", 64'(tlp_count), 64'd3);

        // 5: read during a write; bready held off.
        fork
            do_write(32'h0000_0200, 32'h0BAD_F00D, 4'h1, 0, 0, 4, lat);
            begin
                @(posedge clk); #1;
                do_read(2);
            end
        join
        chk("t5_count", 64'(tlp_count), 64'd4);
        chk("t5_rd_drained", 64'(pend_rd), 64'd0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int rd_on;
            tr_rand = 1'($urandom_range(0, 1));
            cfg_id  = 16'($urandom);
            win     = $urandom;
            bme     = ($urandom_range(0, 7) != 0);
            rd_on   = (it % 3 == 0);
            fork
                do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 3), lat);
                if (rd_on) begin
                    for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                        @(posedge clk); #1;
                    end
                    do_read($urandom_range(0, 3));
                end
            join
        end
        tr_rand = 0;
        bme = 1'b1;
        cfg_id = 16'h0100;
        win = 32'h8000_0000;
        chk("rand_queues_empty", 64'(exp_beats.size() + exp_b.size()), 64'd0);

        // 6: reset while DAT is stalled, then a clean write.
        begin
            int cap;
            bit in_dat = 0;
            tr_pat = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            issue(32'h0000_0300, 32'h5555_AAAA, 4'hF, 0, 0, cap);
            for (int t = 0; t < 20; t++) begin
                @(posedge clk); #1;
                if (ifc.m_axis_tx_tvalid && ifc.m_axis_tx_tlast) begin in_dat = 1; break; end
            end
            chk("t6_reached_dat", 64'(in_dat), 64'd1);
            rst_n = 1'b0;
            exp_beats.delete();
            exp_b.delete();
            model_cnt = 0;
            @(posedge clk); #1;
            tr_pat.delete();
            chk("t6_tvalid", 64'({ifc.m_axis_tx_tvalid, ifc.m_axis_tx_tlast}), 64'd0);
            chk("t6_count", 64'(tlp_count), 64'd0);
            chk("t6_busy_b", 64'({busy, ifc.s_axi_bvalid}), 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("t6_ready", 64'({ifc.s_axi_awready, ifc.s_axi_wready}), 64'd3);
            b_before = n_beats;
            do_write(32'h0000_0ABC, 32'h1122_3344, 4'hF, 0, 0, 0, lat);
            chk("t6_beats", 64'(n_beats - b_before), 64'd2);
            chk("t6_beat0", last_b0, 64'h0100000F_40000001);
            chk("t6_beat1", last_b1, 64'h11223344_80000ABC);
            chk("t6_count_after", 64'(tlp_count), 64'd1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
